// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared encodings for the execute-stage write-back sequencer
package exec_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SGL   = 3'd1,
        ST_MULW  = 3'd2,
        ST_DIVW  = 3'd3,
        ST_WRLO  = 3'd4,
        ST_WRHI  = 3'd5,
        ST_FAULT = 3'd6
    } exec_state_e;

    // Exec classes that need multi-cycle sequencing; every other class is single-cycle
    localparam logic [2:0] EXEC_MUL = 3'd4;
    localparam logic [2:0] EXEC_DIV = 3'd5;

    // Write-back source select codes
    localparam logic [2:0] SEL_ALU = 3'd0;
    localparam logic [2:0] SEL_SHF = 3'd1;
    localparam logic [2:0] SEL_LOG = 3'd2;
    localparam logic [2:0] SEL_MUL = 3'd3;
    localparam logic [2:0] SEL_DIV = 3'd4;
    localparam logic [2:0] SEL_CSR = 3'd5;
    localparam logic [2:0] SEL_IMM = 3'd6;
    localparam logic [2:0] SEL_PC  = 3'd7;

    // oSelOut[SEL_HI_BIT] picks the high half of a two-word result
    localparam int SEL_HI_BIT = 3;

    // Shared down-counter width; covers MUL_LAT-2 and DIV_TMO-1 up to 255
    localparam int CNT_W = 8;

    function automatic logic [3:0] sel_lo(input logic [2:0] src);
        return {1'b0, src};
    endfunction

    function automatic logic [3:0] sel_hi(input logic [2:0] src);
        return {1'b1, src};
    endfunction

endpackage

// File: rtl/exec_seq_cnt.sv
// rtl/exec_seq_cnt.sv - loadable down-counter for multiplier latency and divider watchdog
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : load i_load_val (takes priority over decrement)
//   i_load_val     : value to load
//   i_dec          : decrement by one, saturating at zero
//   o_zero         : counter currently holds zero
module exec_seq_cnt #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/exec_seq.sv
// rtl/exec_seq.sv - execute-stage sequencer for single-cycle, multiply and divide write-back
//
// Parameters:
//   MUL_LAT : cycles from accept to multiplier result at the write-back mux (1..7)
//   DIV_TMO : divider watchdog limit in cycles (only with EXEC_SEQ_DIV_TMO_EN)
// Build option:
//   EXEC_SEQ_DIV_TMO_EN : when defined, DIVW faults after DIV_TMO cycles without iDivDone
// Ports:
//   iClk, iRst_n        : clock, asynchronous active-low reset
//   iStart              : decoder request, sampled only in IDLE
//   iExec, iFunc, iBW   : exec class, function code, word(1)/byte(0) op
//   iSel                : write-back source for single-cycle ops
//   iFlush              : synchronous abort
//   iDivDone, iDivErr   : divider completion and fault qualifier
//   oSelOut             : write-back mux select, bit 3 = hi-word
//   oWrLo, oWrHi        : destination write strobes
//   oDivStart           : divider start pulse
//   oBusy, oDone, oFault: op in flight, final-cycle pulse, divide-fault pulse
module exec_seq
    import exec_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DIV_TMO = 31
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iStart,
    input  logic [2:0] iExec,
    input  logic [3:0] iFunc,
    input  logic       iBW,
    input  logic [2:0] iSel,
    input  logic       iFlush,
    input  logic       iDivDone,
    input  logic       iDivErr,
    output logic [3:0] oSelOut,
    output logic       oWrLo,
    output logic       oWrHi,
    output logic       oDivStart,
    output logic       oBusy,
    output logic       oDone,
    output logic       oFault
);

    // MULW lasts MUL_LAT-1 cycles, so the counter starts one below that
    localparam logic [CNT_W-1:0] L_MUL_LOAD = CNT_W'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

    exec_state_e     r_state;
    exec_state_e     w_next;
    logic [2:0]      r_sel;
    logic            r_bw;
    logic            r_is_div;
    logic [3:0]      r_func;
    logic            r_first;
    logic            w_accept;
    logic            w_cnt_load;
    logic [CNT_W-1:0] w_cnt_val;
    logic            w_cnt_dec;
    logic            w_cnt_zero;
    logic            w_unused;

    assign w_accept = (r_state == ST_IDLE) && iStart && !iFlush;

    // The sign selector only steers the datapath units, not the sequencing
    assign w_unused = ^{r_func, 1'(DIV_TMO)};

    exec_seq_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .i_clk      (iClk),
        .i_rst_n    (iRst_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state  <= ST_IDLE;
            r_sel    <= '0;
            r_bw     <= 1'b0;
            r_is_div <= 1'b0;
            r_func   <= '0;
            r_first  <= 1'b0;
        end else begin
            r_state <= w_next;
            // oDivStart must fire only on the cycle DIVW is entered
            r_first <= w_accept && (w_next == ST_DIVW);
            if (w_accept) begin
                r_sel    <= iSel;
                r_bw     <= iBW;
                r_is_div <= (iExec == EXEC_DIV);
                r_func   <= iFunc;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        oSelOut    = '0;
        oWrLo      = 1'b0;
        oWrHi      = 1'b0;
        oDivStart  = 1'b0;
        oDone      = 1'b0;
        oFault     = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_val  = '0;
        w_cnt_dec  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (iExec == EXEC_MUL) begin
                        if (MUL_LAT <= 1) begin
                            w_next = ST_WRLO;
                        end else begin
                            w_next     = ST_MULW;
                            w_cnt_load = 1'b1;
                            w_cnt_val  = L_MUL_LOAD;
                        end
                    end else if (iExec == EXEC_DIV) begin
                        w_next = ST_DIVW;
`ifdef EXEC_SEQ_DIV_TMO_EN
                        w_cnt_load = 1'b1;
                        w_cnt_val  = CNT_W'((DIV_TMO > 1) ? (DIV_TMO - 1) : 0);
`endif
                    end else begin
                        w_next = ST_SGL;
                    end
                end
            end
            ST_SGL: begin
                oSelOut = sel_lo(r_sel);
                oWrLo   = 1'b1;
                oDone   = 1'b1;
                w_next  = ST_IDLE;
            end
            ST_MULW: begin
                if (w_cnt_zero) begin
                    w_next = ST_WRLO;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_DIVW: begin
                oDivStart = r_first;
                if (iDivDone) begin
                    w_next = iDivErr ? ST_FAULT : ST_WRLO;
                end
`ifdef EXEC_SEQ_DIV_TMO_EN
                // Completion on the limit cycle takes precedence over the timeout
                else if (w_cnt_zero) begin
                    w_next = ST_FAULT;
                end else begin
                    w_cnt_dec = 1'b1;
                end
`endif
            end
            ST_WRLO: begin
                oSelOut = sel_lo(r_is_div ? SEL_DIV : SEL_MUL);
                oWrLo   = 1'b1;
                // Divide always writes quotient and remainder; byte multiply has no high half
                if (r_is_div || r_bw) begin
                    w_next = ST_WRHI;
                end else begin
                    oDone  = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            ST_WRHI: begin
                oSelOut = sel_hi(r_is_div ? SEL_DIV : SEL_MUL);
                oWrHi   = 1'b1;
                oDone   = 1'b1;
                w_next  = ST_IDLE;
            end
            ST_FAULT: begin
                oFault = 1'b1;
                oDone  = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase

        // Flush silences the current cycle entirely and abandons the op
        if ((r_state != ST_IDLE) && iFlush) begin
            w_next     = ST_IDLE;
            oSelOut    = '0;
            oWrLo      = 1'b0;
            oWrHi      = 1'b0;
            oDivStart  = 1'b0;
            oDone      = 1'b0;
            oFault     = 1'b0;
            w_cnt_load = 1'b0;
            w_cnt_dec  = 1'b0;
        end
    end

    assign oBusy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_exec_seq.sv
// tb/tb_exec_seq.sv - randomized scoreboard bench for exec_seq
module tb_exec_seq;

    localparam int L   = 2;
    localparam int TMO = 31;

    logic       iClk = 1'b0;
    logic       iRst_n = 1'b0;
    logic       iStart = 1'b0;
    logic [2:0] iExec = '0;
    logic [3:0] iFunc = '0;
    logic       iBW = 1'b0;
    logic [2:0] iSel = '0;
    logic       iFlush = 1'b0;
    logic       iDivDone = 1'b0;
    logic       iDivErr = 1'b0;
    logic [3:0] oSelOut;
    logic       oWrLo, oWrHi, oDivStart, oBusy, oDone, oFault;

    exec_seq #(.MUL_LAT(L), .DIV_TMO(TMO)) dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iStart    (iStart),
        .iExec     (iExec),
        .iFunc     (iFunc),
        .iBW       (iBW),
        .iSel      (iSel),
        .iFlush    (iFlush),
        .iDivDone  (iDivDone),
        .iDivErr   (iDivErr),
        .oSelOut   (oSelOut),
        .oWrLo     (oWrLo),
        .oWrHi     (oWrHi),
        .oDivStart (oDivStart),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oFault    (oFault)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [3:0] sel;
        logic       lo, hi, ds, dn, ft;
    } ev_t;

    ev_t q[$];
    int  busy_lo = 1;
    int  busy_hi = 0;
    int  total = 0;
    int  bad = 0;
    bit  mon_en = 0;

    logic [2:0] sgl_tab [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

    // Monitor: samples mid-cycle, pops expected strobe events and checks oBusy
    initial forever begin
        @(negedge iClk);
        #1;
        if (mon_en) begin
            total++;
            if (oBusy !== ((cyc >= busy_lo) && (cyc <= busy_hi))) begin
                bad++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, oBusy, (cyc >= busy_lo) && (cyc <= busy_hi));
            end
            total++;
            if ({oWrLo, oWrHi, oDivStart, oDone, oFault} !== 5'b0) begin
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_strobe cyc=%0d got sel=%0d lo=%b hi=%b ds=%b dn=%b ft=%b exp=none",
                             cyc, oSelOut, oWrLo, oWrHi, oDivStart, oDone, oFault);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    if (e.c != cyc || e.sel !== oSelOut || e.lo !== oWrLo || e.hi !== oWrHi ||
                        e.ds !== oDivStart || e.dn !== oDone || e.ft !== oFault) begin
                        bad++;
                        $display("FAIL event got cyc=%0d sel=%0d lo=%b hi=%b ds=%b dn=%b ft=%b exp cyc=%0d sel=%0d lo=%b hi=%b ds=%b dn=%b ft=%b",
                                 cyc, oSelOut, oWrLo, oWrHi, oDivStart, oDone, oFault,
                                 e.c, e.sel, e.lo, e.hi, e.ds, e.dn, e.ft);
                    end
                end
            end else if (q.size() > 0 && q[0].c <= cyc) begin
                bad++;
                $display("FAIL missed_event cyc=%0d got=none exp cyc=%0d sel=%0d", cyc, q[0].c, q[0].sel);
                void'(q.pop_front());
            end else if (oSelOut !== 4'd0) begin
                bad++;
                $display("FAIL sel_idle cyc=%0d got=%0d exp=0", cyc, oSelOut);
            end
        end
    end

    task automatic add_ev(inout ev_t evs[$], input int off, input logic [3:0] sel,
                          input logic lo, input logic hi, input logic ds, input logic dn, input logic ft);
        ev_t e;
        e.c = off; e.sel = sel; e.lo = lo; e.hi = hi; e.ds = ds; e.dn = dn; e.ft = ft;
        evs.push_back(e);
    endtask

    // kind: 0 single-cycle, 1 MUL, 2 DIV, 3 start dropped by flush in IDLE
    // d: cycle offset of iDivDone (>=1000 means never); cut: flush/reset offset (0 = none)
    task automatic do_op(input int kind, input logic [2:0] ex, input bit bw, input logic [2:0] sel,
                         input int d, input bit err, input int cut_in, input bit use_rst);
        int   a, e_off, last, cut;
        ev_t  evs[$];
        @(negedge iClk);
        a = cyc;
        cut = cut_in;
        iRst_n = 1'b1;
        iStart = 1'b1;
        iFlush = (kind == 3);
        iFunc = 4'($urandom);
        iBW = bw;
        iSel = sel;
        iDivDone = 1'($urandom);
        iDivErr = 1'($urandom);
        case (kind)
            0: iExec = ex;
            1: iExec = 3'd4;
            2: iExec = 3'd5;
            default: iExec = 3'($urandom);
        endcase
        if (kind == 3) begin
            @(posedge iClk);
            return;
        end
        e_off = 0;
        if (kind == 0) begin
            add_ev(evs, 1, {1'b0, sel}, 1, 0, 0, 1, 0);
            e_off = 1;
        end else if (kind == 1) begin
            add_ev(evs, L, 4'd3, 1, 0, 0, !bw, 0);
            if (bw) add_ev(evs, L + 1, 4'd11, 0, 1, 0, 1, 0);
            e_off = L + (bw ? 1 : 0);
        end else begin
            add_ev(evs, 1, 4'd0, 0, 0, 1, 0, 0);
            if (d >= 1000) begin
                add_ev(evs, TMO + 1, 4'd0, 0, 0, 0, 1, 1);
                e_off = TMO + 1;
            end else if (err) begin
                add_ev(evs, d + 1, 4'd0, 0, 0, 0, 1, 1);
                e_off = d + 1;
            end else begin
                add_ev(evs, d + 1, 4'd4, 1, 0, 0, 0, 0);
                add_ev(evs, d + 2, 4'd12, 0, 1, 0, 1, 0);
                e_off = d + 2;
            end
        end
        if (cut > e_off) cut = 0;
        last = (cut > 0) ? cut : e_off;
        foreach (evs[i]) begin
            if (cut == 0 || evs[i].c < cut) begin
                ev_t e;
                e = evs[i];
                e.c = a + e.c;
                q.push_back(e);
            end
        end
        busy_lo = a + 1;
        busy_hi = (cut > 0 && use_rst) ? a + cut - 1 : a + last;
        @(posedge iClk);
        for (int k = 1; k <= last; k++) begin
            @(negedge iClk);
            iStart = 1'($urandom);
            iExec = 3'($urandom);
            iSel = 3'($urandom);
            iBW = 1'($urandom);
            iFunc = 4'($urandom);
            iDivDone = (kind == 2) ? ((k == d) || (k > d && $urandom_range(0, 1) == 1)) : 1'($urandom);
            iDivErr = (kind == 2 && k == d) ? err : 1'($urandom);
            iFlush = (cut == k) && !use_rst;
            if (cut == k && use_rst) iRst_n = 1'b0;
            @(posedge iClk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        #1;
        total++;
        if ({oSelOut, oWrLo, oWrHi, oDivStart, oBusy, oDone, oFault} !== 10'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0", {oSelOut, oWrLo, oWrHi, oDivStart, oBusy, oDone, oFault});
        end
        mon_en = 1;
        iRst_n = 1'b1;

        do_op(0, 3'd0, 0, 3'd6, 0, 0, 0, 0);
        do_op(1, 3'd0, 1, 3'd0, 0, 0, 0, 0);
        do_op(1, 3'd0, 0, 3'd0, 0, 0, 0, 0);
        do_op(2, 3'd0, 0, 3'd0, 10, 1, 0, 0);
        do_op(2, 3'd0, 0, 3'd0, 1, 0, 0, 0);
        do_op(2, 3'd0, 0, 3'd0, TMO, 0, 0, 0);
`ifdef EXEC_SEQ_DIV_TMO_EN
        do_op(2, 3'd0, 0, 3'd0, 1000, 0, 0, 0);
`endif
        do_op(1, 3'd0, 1, 3'd0, 0, 0, 1, 0);
        do_op(1, 3'd0, 1, 3'd0, 0, 0, L, 1);
        do_op(3, 3'd0, 0, 3'd0, 0, 0, 0, 0);
        do_op(0, 3'd7, 0, 3'd2, 0, 0, 0, 0);

        for (int n = 0; n < 200; n++) begin
            int  kind, cut;
            bit  rst;
            kind = $urandom_range(0, 3);
            cut = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
            rst = (cut > 0) && ($urandom_range(0, 1) == 1);
            do_op(kind, sgl_tab[$urandom_range(0, 5)], 1'($urandom), 3'($urandom),
                  $urandom_range(1, 20), 1'($urandom), cut, rst);
        end

        @(negedge iClk);
        iRst_n = 1'b1;
        iStart = 1'b0;
        iFlush = 1'b0;
        iDivDone = 1'b0;
        repeat (6) @(negedge iClk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL leftover_events got=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
